crc_frame_packer: RTL and testbench

Upstream framing stage of the FEC datapath. It accepts one DATA_WIDTH data word over a valid/ready handshake and computes its CRC serially, XOR_OPS_PER_CYCLE bits per cycle. It then presents the frame {data, crc}, data in the MSBs, on a valid/ready output. That frame is what the downstream CRC verifier and channel stages consume; a correctly packed frame leaves a zero remainder.

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_step_comb.sv | 44 ++++
 rtl/crc_frame_packer.sv | 164 ++++++++++++++++
 tb/tb_crc_frame_packer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC framing/verification datapath.
package crc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_HOLD
    } state_e;

    localparam logic [4:0] DEFAULT_POLY = 5'b10011;
    localparam logic [3:0] DEFAULT_SEED = 4'h0;

    // Clock edges from accept to frame-valid for a given datapath width and bits per cycle.
    function automatic int unsigned calc_latency(input int unsigned data_width,
                                                 input int unsigned ops_per_cycle);
        return (data_width + ops_per_cycle - 1) / ops_per_cycle;
    endfunction

endpackage

// File: rtl/crc_step_comb.sv
// Combinational CRC advance: up to XOR_OPS_PER_CYCLE MSB-first bit-steps, stopping at counter 0.
// Shared between the frame packer and the downstream verifier.
module crc_step_comb #(
    parameter int unsigned          DATA_WIDTH        = 12,
    parameter int unsigned          CRC_WIDTH         = 4,
    parameter logic [CRC_WIDTH:0]   POLY              = 5'b10011,
    parameter int unsigned          XOR_OPS_PER_CYCLE = 1,
    parameter int unsigned          CNT_W             = $clog2(DATA_WIDTH + 1)
) (
    input  logic [DATA_WIDTH-1:0] shreg,
    input  logic [CRC_WIDTH-1:0]  crc,
    input  logic [CNT_W-1:0]      counter,
    output logic [DATA_WIDTH-1:0] shreg_next,
    output logic [CRC_WIDTH-1:0]  crc_next,
    output logic [CNT_W-1:0]      counter_next
);

    localparam logic [CRC_WIDTH-1:0] POLY_LO = POLY[CRC_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] sh_v;
    logic [CRC_WIDTH-1:0]  crc_v;
    logic [CNT_W-1:0]      cnt_v;
    logic                  fb;

    always_comb begin
        sh_v  = shreg;
        crc_v = crc;
        cnt_v = counter;
        fb    = 1'b0;
        for (int unsigned i = 0; i < XOR_OPS_PER_CYCLE; i++) begin
            // Counter gating yields min(ops, counter) steps and prevents underflow.
            if (cnt_v != '0) begin
                fb    = sh_v[DATA_WIDTH-1] ^ crc_v[CRC_WIDTH-1];
                crc_v = (crc_v << 1) ^ (fb ? POLY_LO : '0);
                sh_v  = sh_v << 1;
                cnt_v = cnt_v - 1'b1;
            end
        end
        shreg_next   = sh_v;
        crc_next     = crc_v;
        counter_next = cnt_v;
    end

endmodule

// File: rtl/crc_frame_packer.sv
// Accepts one payload word, computes its CRC serially and presents {payload, crc} downstream.
// Optional error injection on frame bit 0 is enabled by defining CRC_FRAME_PACKER_ERR_INJ_EN.
module crc_frame_packer
    import crc_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH        = 12,
    parameter int unsigned          CRC_WIDTH         = 4,
    parameter logic [CRC_WIDTH:0]   POLY              = DEFAULT_POLY,
    parameter logic [CRC_WIDTH-1:0] SEED              = '0,
    parameter int unsigned          XOR_OPS_PER_CYCLE = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH+CRC_WIDTH-1:0] out_frame,
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
    input  logic                            err_inj,
    output logic [15:0]                     inj_count,
`endif
    output logic                            busy
);

    localparam int unsigned FRAME_W = DATA_WIDTH + CRC_WIDTH;
    localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);

    if (XOR_OPS_PER_CYCLE < 1 || XOR_OPS_PER_CYCLE > DATA_WIDTH) begin : g_bad_ops
        $error("crc_frame_packer: XOR_OPS_PER_CYCLE must be within 1..DATA_WIDTH");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] payload_q, payload_d;
    logic [CRC_WIDTH-1:0]  crc_q, crc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [FRAME_W-1:0]    out_frame_q, out_frame_d;

    logic [DATA_WIDTH-1:0] shreg_step;
    logic [CRC_WIDTH-1:0]  crc_step;
    logic [CNT_W-1:0]      cnt_step;
    logic [FRAME_W-1:0]    inj_mask;

`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
    logic        inj_pend_q, inj_pend_d;
    logic [15:0] inj_count_q, inj_count_d;

    assign inj_mask  = FRAME_W'(inj_pend_q);
    assign inj_count = inj_count_q;
`else
    assign inj_mask  = '0;
`endif

    crc_step_comb #(
        .DATA_WIDTH        (DATA_WIDTH),
        .CRC_WIDTH         (CRC_WIDTH),
        .POLY              (POLY),
        .XOR_OPS_PER_CYCLE (XOR_OPS_PER_CYCLE),
        .CNT_W             (CNT_W)
    ) u_step (
        .shreg        (shreg_q),
        .crc          (crc_q),
        .counter      (cnt_q),
        .shreg_next   (shreg_step),
        .crc_next     (crc_step),
        .counter_next (cnt_step)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        payload_d   = payload_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_frame_d = out_frame_q;
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
        inj_pend_d  = inj_pend_q;
        inj_count_d = inj_count_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    payload_d = in_data;
                    crc_d     = SEED;
                    cnt_d     = CNT_LOAD;
                    state_d   = S_CALC;
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
                    inj_pend_d = err_inj;
`endif
                end
            end
            S_CALC: begin
                shreg_d = shreg_step;
                crc_d   = crc_step;
                cnt_d   = cnt_step;
                // Frame loads on the same edge the last bit-step completes.
                if (cnt_step == '0) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    out_frame_d = {payload_q, crc_step} ^ inj_mask;
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
                    if (inj_pend_q) begin
                        inj_count_d = inj_count_q + 16'd1;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            payload_q   <= '0;
            crc_q       <= SEED;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_frame_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            payload_q   <= payload_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_frame_q <= out_frame_d;
        end
    end

`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pend_q  <= 1'b0;
            inj_count_q <= '0;
        end else begin
            inj_pend_q  <= inj_pend_d;
            inj_count_q <= inj_count_d;
        end
    end
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC) || (state_q == S_HOLD);
    assign out_valid = out_valid_q;
    assign out_frame = out_frame_q;

endmodule

// File: tb/tb_crc_frame_packer.sv
// Directed bench for crc_frame_packer at 1, 5 and 12 CRC bit-steps per cycle.
module tb_crc_frame_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic [11:0] in_data_a   [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic [15:0] out_frame_a [3];
    logic        busy_a      [3];
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
    logic        err_inj_a   [3];
    logic [15:0] inj_count_a [3];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned OPS = (g == 0) ? 1 : ((g == 1) ? 5 : 12);
        crc_frame_packer #(
            .DATA_WIDTH        (12),
            .CRC_WIDTH         (4),
            .POLY              (5'b10011),
            .SEED              (4'h0),
            .XOR_OPS_PER_CYCLE (OPS)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_frame (out_frame_a[g]),
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
            .err_inj   (err_inj_a[g]),
            .inj_count (inj_count_a[g]),
`endif
            .busy      (busy_a[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            in_data_a[i]   = '0;
            out_ready_a[i] = 1'b0;
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
            err_inj_a[i]   = 1'b0;
`endif
        end
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (in_ready_a[0] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_a[0]); end
        n_cmp++; if (out_valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a[0]); end
        n_cmp++; if (out_frame_a[0] !== 16'h0000) begin n_bad++; $display("FAIL reset_out_frame: got %h expected 0000", out_frame_a[0]); end
        n_cmp++; if (busy_a[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_a[0]); end
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
        n_cmp++; if (inj_count_a[0] !== 16'd0) begin n_bad++; $display("FAIL reset_inj_count: got %0d expected 0", inj_count_a[0]); end
`endif
        #9 rst_n = 1'b1;
        tick();
    endtask

    // One frame with out_ready held high: checks latency, frame, in_ready-low span and release.
    task automatic run_frame(input int sel, input logic [11:0] data, input logic [15:0] exp_frame,
                             input int exp_lat, input string name);
        int lat;
        int low;
        in_data_a[sel]   = data;
        in_valid_a[sel]  = 1'b1;
        out_ready_a[sel] = 1'b1;
        tick();
        in_valid_a[sel] = 1'b0;
        lat = 0;
        low = (in_ready_a[sel] === 1'b0) ? 1 : 0;
        while (out_valid_a[sel] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (in_ready_a[sel] === 1'b0) low++;
        end
        n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        n_cmp++; if (out_frame_a[sel] !== exp_frame) begin n_bad++; $display("FAIL %s_frame: got %h expected %h", name, out_frame_a[sel], exp_frame); end
        n_cmp++; if (low != exp_lat + 1) begin n_bad++; $display("FAIL %s_in_ready_low: got %0d expected %0d", name, low, exp_lat + 1); end
        tick();
        n_cmp++; if (in_ready_a[sel] !== 1'b1 || out_valid_a[sel] !== 1'b0) begin
            n_bad++; $display("FAIL %s_release: got in_ready=%b out_valid=%b expected 1 0", name, in_ready_a[sel], out_valid_a[sel]);
        end
    endtask

    task automatic test_basic();
        run_frame(0, 12'h800, 16'h8001, 12, "ops1_800");
        run_frame(0, 12'h001, 16'h0013, 12, "ops1_001");
        run_frame(0, 12'h000, 16'h0000, 12, "ops1_000");
    endtask

    task automatic test_multi_step();
        run_frame(1, 12'h800, 16'h8001, 3, "ops5_800");
        run_frame(1, 12'h001, 16'h0013, 3, "ops5_001");
        run_frame(2, 12'h800, 16'h8001, 1, "ops12_800");
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_ready_a[0] = 1'b0;
        in_data_a[0]   = 12'h001;
        in_valid_a[0]  = 1'b1;
        tick();
        in_valid_a[0] = 1'b0;
        lat = 0;
        while (out_valid_a[0] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL hold_latency: got %0d expected 12", lat); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid_a[0] = i[0];
            in_data_a[0]  = 12'hFFF;
            tick();
            if (out_frame_a[0] !== 16'h0013 || in_ready_a[0] !== 1'b0 || out_valid_a[0] !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        tick();
        n_cmp++; if (out_valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL hold_transfer_valid: got %b expected 0", out_valid_a[0]); end
        n_cmp++; if (in_ready_a[0] !== 1'b1) begin n_bad++; $display("FAIL hold_transfer_ready: got %b expected 1", in_ready_a[0]); end
        tick();
        n_cmp++; if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
            n_bad++; $display("FAIL hold_single_transfer: got out_valid=%b busy=%b expected 0 0", out_valid_a[0], busy_a[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        in_data_a[0]   = 12'h800;
        in_valid_a[0]  = 1'b1;
        out_ready_a[0] = 1'b1;
        tick();
        in_valid_a[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (busy_a[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before: got %b expected 1", busy_a[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid_a[0]); end
        n_cmp++; if (in_ready_a[0] !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready_a[0]); end
        n_cmp++; if (busy_a[0] !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b expected 0", busy_a[0]); end
        #3 rst_n = 1'b1;
        run_frame(0, 12'h001, 16'h0013, 12, "after_reset");
    endtask

`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
    task automatic test_err_inj();
        err_inj_a[0] = 1'b1;
        run_frame(0, 12'h001, 16'h0012, 12, "inj_on");
        n_cmp++; if (inj_count_a[0] !== 16'd1) begin n_bad++; $display("FAIL inj_count_one: got %0d expected 1", inj_count_a[0]); end
        err_inj_a[0] = 1'b0;
        run_frame(0, 12'h001, 16'h0013, 12, "inj_off");
        n_cmp++; if (inj_count_a[0] !== 16'd1) begin n_bad++; $display("FAIL inj_count_hold: got %0d expected 1", inj_count_a[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_multi_step();
        test_backpressure();
        test_reset_mid_frame();
`ifdef CRC_FRAME_PACKER_ERR_INJ_EN
        test_err_inj();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
